// File: rtl/race_ctrl_pkg.sv
// ============================================================================
// Module : race_ctrl_pkg
// Brief  : Shared types and constants for the race controller and cell array.
//          The ST_TB state exists only when RACE_TB_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package race_ctrl_pkg;

  localparam int EDGE_WIDTH      = 4;
  localparam int DELAY_WIDTH     = 8;
  localparam int DEF_SCORE_WIDTH = 8;

  typedef logic [EDGE_WIDTH-1:0] edge_vec;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RACE  = 3'd2,
    ST_DONE  = 3'd3
`ifdef RACE_TB_EN
    ,
    ST_TB    = 3'd4
`endif
  } race_state_e;

endpackage

`default_nettype wire

// File: rtl/race_ctrl_if.sv
// ============================================================================
// Module : race_ctrl_if
// Brief  : Start/score handshakes and cell-array race signals of race_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface race_ctrl_if
  import race_ctrl_pkg::*;
#(
  parameter int SCORE_WIDTH = DEF_SCORE_WIDTH
) ();

  logic                   start_valid;
  logic                   start_ready;
  logic                   array_clr;
  edge_vec                launch;
  edge_vec                arrive;
  logic                   score_valid;
  logic                   score_ready;
  logic [SCORE_WIDTH-1:0] score;
  logic                   score_sat;
  logic                   tb_shift_en;
  logic                   tb_done;

  modport slave (
    input  start_valid, arrive, score_ready,
    output start_ready, array_clr, launch, score_valid, score, score_sat,
           tb_shift_en, tb_done
  );

  modport master (
    output start_valid, arrive, score_ready,
    input  start_ready, array_clr, launch, score_valid, score, score_sat,
           tb_shift_en, tb_done
  );

endinterface

`default_nettype wire

// File: rtl/race_ctrl_sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Up-counter that sticks at all-ones; shared by controller and cells.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] value,
  output logic             at_max
);

  logic [WIDTH-1:0] value_q, value_d;

  assign at_max = &value_q;
  assign value  = value_q;

  always_comb begin
    value_d = value_q;
    if (clr)
      value_d = '0;
    else if (inc && !at_max)
      value_d = value_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      value_q <= '0;
    else
      value_q <= value_d;
  end

endmodule

`default_nettype wire

// File: rtl/race_ctrl.sv
// ============================================================================
// Module : race_ctrl
// Brief  : Clears the cell array, launches the race edge, times the arrival
//          and returns the score; RACE_TB_EN adds a traceback shift phase.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module race_ctrl
  import race_ctrl_pkg::*;
#(
  parameter int SCORE_WIDTH = DEF_SCORE_WIDTH,
  parameter int CLR_CYCLES  = 2,
  parameter int TB_LEN      = 16
) (
  input  logic        clk,
  input  logic        rst,
  race_ctrl_if.slave  bus
);

  localparam int                     CLR_W     = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0]       CLR_LAST  = CLR_W'(CLR_CYCLES - 1);
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = '1;

  race_state_e            state_q, state_d;
  logic [CLR_W-1:0]       clr_cnt_q, clr_cnt_d;
  logic                   start_ready_q, start_ready_d;
  logic                   array_clr_q, array_clr_d;
  edge_vec                launch_q, launch_d;
  logic                   score_valid_q, score_valid_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic                   score_sat_q, score_sat_d;
  logic                   tb_shift_en_q, tb_shift_en_d;
  logic                   tb_done_q, tb_done_d;

  logic [SCORE_WIDTH-1:0] ctr;
  logic                   ctr_at_max;
  logic                   arrival;

  assign arrival = |bus.arrive;

  sat_counter #(
    .WIDTH (SCORE_WIDTH)
  ) u_ctr (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == ST_CLEAR),
    .inc    ((state_q == ST_RACE) && !arrival),
    .value  (ctr),
    .at_max (ctr_at_max)
  );

`ifdef RACE_TB_EN
  localparam int              TB_W    = (TB_LEN > 1) ? $clog2(TB_LEN) : 1;
  localparam logic [TB_W-1:0] TB_LAST = TB_W'(TB_LEN - 1);
  logic [TB_W-1:0]            tb_cnt_q, tb_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    score_d     = score_q;
    score_sat_d = score_sat_q;
    tb_done_d   = 1'b0;
`ifdef RACE_TB_EN
    tb_cnt_d    = tb_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        clr_cnt_d = '0;
        if (bus.start_valid)
          state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (clr_cnt_q == CLR_LAST)
          state_d = ST_RACE;
        else
          clr_cnt_d = clr_cnt_q + 1'b1;
      end
      ST_RACE: begin
        // An arrival in the saturating cycle still counts as a real alignment.
        if (arrival) begin
          score_d     = ctr;
          score_sat_d = 1'b0;
          state_d     = ST_DONE;
        end else if (ctr_at_max) begin
          score_d     = SCORE_MAX;
          score_sat_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.score_ready) begin
`ifdef RACE_TB_EN
          state_d  = ST_TB;
          tb_cnt_d = '0;
`else
          state_d  = ST_IDLE;
`endif
        end
      end
`ifdef RACE_TB_EN
      ST_TB: begin
        if (tb_cnt_q == TB_LAST) begin
          state_d   = ST_IDLE;
          tb_done_d = 1'b1;
        end else begin
          tb_cnt_d = tb_cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    start_ready_d = (state_d == ST_IDLE);
    array_clr_d   = (state_d == ST_CLEAR);
    score_valid_d = (state_d == ST_DONE);
    // Launch stays high through DONE/TB/IDLE so cell edges survive for traceback.
    launch_d = launch_q;
    if (state_d == ST_CLEAR)
      launch_d = '0;
    else if (state_d == ST_RACE)
      launch_d = '1;
`ifdef RACE_TB_EN
    tb_shift_en_d = (state_d == ST_TB);
`else
    tb_shift_en_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      clr_cnt_q     <= '0;
      start_ready_q <= 1'b1;
      array_clr_q   <= 1'b0;
      launch_q      <= '0;
      score_valid_q <= 1'b0;
      score_q       <= '0;
      score_sat_q   <= 1'b0;
      tb_shift_en_q <= 1'b0;
      tb_done_q     <= 1'b0;
`ifdef RACE_TB_EN
      tb_cnt_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      start_ready_q <= start_ready_d;
      array_clr_q   <= array_clr_d;
      launch_q      <= launch_d;
      score_valid_q <= score_valid_d;
      score_q       <= score_d;
      score_sat_q   <= score_sat_d;
      tb_shift_en_q <= tb_shift_en_d;
      tb_done_q     <= tb_done_d;
`ifdef RACE_TB_EN
      tb_cnt_q      <= tb_cnt_d;
`endif
    end
  end

  assign bus.start_ready = start_ready_q;
  assign bus.array_clr   = array_clr_q;
  assign bus.launch      = launch_q;
  assign bus.score_valid = score_valid_q;
  assign bus.score       = score_q;
  assign bus.score_sat   = score_sat_q;
  assign bus.tb_shift_en = tb_shift_en_q;
  assign bus.tb_done     = tb_done_q;

endmodule

`default_nettype wire
